// File: rtl/dma_dcpl_drain_pkg.sv
// Shared types and default constants for the DMA decouple-drain block.
package dma_dcpl_drain_pkg;

    localparam int N_OUTSTANDING_DEF = 16;
    localparam int DRAIN_TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_DRAIN,
        ST_DECOUPLED
    } drain_state_t;

    // DMA request descriptor passed through untouched.
    typedef struct packed {
        logic [47:0] vaddr;
        logic [27:0] len;
        logic        last;
    } dma_req_t;

    // Completion indication returned by the DMA engine.
    typedef struct packed {
        logic done;
    } dma_rsp_t;

endpackage

// File: rtl/dma_dcpl_drain_if.sv
// DMA request channel: descriptor with valid/ready plus a completion strobe.
interface dma_dcpl_drain_if;
    import dma_dcpl_drain_pkg::*;

    dma_req_t req;
    logic     valid;
    logic     ready;
    dma_rsp_t rsp;

    // Requester side: issues descriptors, receives ready and completions.
    modport m (output req, output valid, input ready, input rsp);
    // Responder side: accepts descriptors, returns ready and completions.
    modport s (input req, input valid, output ready, output rsp);

endinterface

// File: rtl/dma_dcpl_drain_outstanding_cnt.sv
// Up/down counter of in-flight DMA requests with floor saturation.
// cnt_upd is the next value before any clear, so callers can look ahead
// without creating a loop through their own clear decision.
module dma_outstanding_cnt #(
    parameter int CNT_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    input  logic                clr,
    output logic [CNT_BITS-1:0] cnt,
    output logic [CNT_BITS-1:0] cnt_upd,
    output logic                underflow
);

    // Next count: simultaneous inc/dec cancel, dec at zero stays at zero.
    always_comb begin
        cnt_upd   = cnt;
        underflow = 1'b0;
        if (inc && !dec) begin
            cnt_upd = cnt + CNT_BITS'(1);
        end else if (dec && !inc) begin
            if (cnt == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_upd = cnt - CNT_BITS'(1);
            end
        end
    end

    // Count register; clear drops all tracked requests at once.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_upd;
        end
    end

endmodule

// File: rtl/dma_dcpl_drain.sv
// Credit-limits DMA requests and drains in-flight traffic before asserting
// decouple, so reconfiguration never cuts an active transfer.
module dma_dcpl_drain
    import dma_dcpl_drain_pkg::*;
#(
    parameter int N_OUTSTANDING = N_OUTSTANDING_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
    localparam int CNT_BITS = $clog2(N_OUTSTANDING + 1)
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                decouple_req,
    output logic                decouple,
    output logic                drain_busy,
    output logic [CNT_BITS-1:0] outstanding,
    output logic                drain_timeout,
    output logic                rsp_underflow,
    input  logic                clr_flags,
    dma_dcpl_drain_if.s         s_req,
    dma_dcpl_drain_if.m         m_req
);

    localparam int TO_BITS = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam bit TO_EN = (DRAIN_TIMEOUT != 0);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
    localparam logic [CNT_BITS-1:0] CNT_LIMIT = CNT_BITS'(N_OUTSTANDING);

    drain_state_t        state;
    drain_state_t        state_nxt;
    logic [TO_BITS-1:0]  tcnt;
    logic [CNT_BITS-1:0] cnt_upd;
    logic                issue_ok;
    logic                issue;
    logic                inc;
    logic                dec;
    logic                cnt_clr;
    logic                cnt_uf;
    logic                to_hit;
    logic                to_exit;

    // Descriptor and completion pass straight through.
    assign m_req.req = s_req.req;
    assign s_req.rsp = m_req.rsp;

    // The gate is built from registered state only, so valid never feeds ready.
    assign issue_ok    = (state == ST_ACTIVE) && (outstanding < CNT_LIMIT);
    assign issue       = s_req.valid && issue_ok;
    assign m_req.valid = issue;
    assign s_req.ready = m_req.ready && issue_ok;

    assign inc        = issue && m_req.ready;
    assign dec        = m_req.rsp.done;
    assign drain_busy = (state == ST_DRAIN);
    assign to_hit     = TO_EN && (tcnt == TO_LAST);

    // Completions are masked downstream once decoupled, so the count is dropped.
    assign cnt_clr = (state_nxt == ST_DECOUPLED);

    dma_outstanding_cnt #(
        .CNT_BITS (CNT_BITS)
    ) u_cnt (
        .clk       (aclk),
        .rst       (areset),
        .inc       (inc),
        .dec       (dec),
        .clr       (cnt_clr),
        .cnt       (outstanding),
        .cnt_upd   (cnt_upd),
        .underflow (cnt_uf)
    );

    // Next-state logic; a drain that empties wins over a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        to_exit   = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (decouple_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!decouple_req) begin
                    state_nxt = ST_ACTIVE;
                end else if (cnt_upd == '0) begin
                    state_nxt = ST_DECOUPLED;
                end else if (to_hit) begin
                    state_nxt = ST_DECOUPLED;
                    to_exit   = 1'b1;
                end
            end
            ST_DECOUPLED: begin
                if (!decouple_req) state_nxt = ST_ACTIVE;
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    // State register and registered decouple output.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= ST_ACTIVE;
            decouple <= 1'b0;
        end else begin
            state    <= state_nxt;
            decouple <= (state_nxt == ST_DECOUPLED);
        end
    end

    // Drain timer runs only while staying in DRAIN.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tcnt <= '0;
        end else if (state == ST_DRAIN && state_nxt == ST_DRAIN) begin
            tcnt <= tcnt + TO_BITS'(1);
        end else begin
            tcnt <= '0;
        end
    end

    // Sticky flags; a set in the same cycle as a clear takes precedence.
    always_ff @(posedge aclk) begin
        if (areset) begin
            drain_timeout <= 1'b0;
            rsp_underflow <= 1'b0;
        end else begin
            if (to_exit) begin
                drain_timeout <= 1'b1;
            end else if (clr_flags) begin
                drain_timeout <= 1'b0;
            end
            if (cnt_uf && !cnt_clr) begin
                rsp_underflow <= 1'b1;
            end else if (clr_flags) begin
                rsp_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_dcpl_drain.sv
// Bench for dma_dcpl_drain: two instances (credit 4 / timeout 16 and
// credit 8 / no timeout) share one stimulus and are each compared every
// cycle against a transaction-level model, plus directed spot checks.
module tb_dma_dcpl_drain;
    import dma_dcpl_drain_pkg::*;

    localparam int NA = 4;
    localparam int TA = 16;
    localparam int NB = 8;
    localparam int TB = 0;
    localparam int M_ACT = 0;
    localparam int M_DRN = 1;
    localparam int M_DEC = 2;

    typedef struct packed {
        int mode;
        int inflight;
        int waited;
        bit dcpl;
        bit to_flag;
        bit uf_flag;
    } mdl_t;

    logic     clk = 1'b0;
    logic     rst_i = 1'b1;
    logic     dreq_i = 1'b0;
    logic     clr_i = 1'b0;
    logic     valid_i = 1'b0;
    logic     rdy_i = 1'b0;
    logic     done_i = 1'b0;
    dma_req_t req_i = '0;

    logic       dcpl_a, busy_a, to_a, uf_a;
    logic [2:0] out_a;
    logic       dcpl_b, busy_b, to_b, uf_b;
    logic [3:0] out_b;

    int   n_vec = 0;
    int   n_mis = 0;
    int   hs_a = 0;
    int   hs_base = 0;
    mdl_t ma_m = '0;
    mdl_t mb_m = '0;

    dma_dcpl_drain_if sa ();
    dma_dcpl_drain_if ma ();
    dma_dcpl_drain_if sb ();
    dma_dcpl_drain_if mb ();

    assign sa.valid    = valid_i;
    assign sa.req      = req_i;
    assign ma.ready    = rdy_i;
    assign ma.rsp.done = done_i;
    assign sb.valid    = valid_i;
    assign sb.req      = req_i;
    assign mb.ready    = rdy_i;
    assign mb.rsp.done = done_i;

    dma_dcpl_drain #(.N_OUTSTANDING(NA), .DRAIN_TIMEOUT(TA)) u_a (
        .aclk(clk), .areset(rst_i), .decouple_req(dreq_i), .decouple(dcpl_a),
        .drain_busy(busy_a), .outstanding(out_a), .drain_timeout(to_a),
        .rsp_underflow(uf_a), .clr_flags(clr_i), .s_req(sa), .m_req(ma)
    );

    dma_dcpl_drain #(.N_OUTSTANDING(NB), .DRAIN_TIMEOUT(TB)) u_b (
        .aclk(clk), .areset(rst_i), .decouple_req(dreq_i), .decouple(dcpl_b),
        .drain_busy(busy_b), .outstanding(out_b), .drain_timeout(to_b),
        .rsp_underflow(uf_b), .clr_flags(clr_i), .s_req(sb), .m_req(mb)
    );

    initial forever #5 clk = ~clk;

    function automatic bit can_issue(mdl_t m, int n_max);
        return (m.mode == M_ACT) && (m.inflight < n_max);
    endfunction

    // Model: one clock of the drain protocol in terms of requests in flight.
    function automatic mdl_t step(mdl_t m, int n_max, int t_max);
        mdl_t n;
        int   after;
        bit   hs;
        bit   uf;
        bit   te;
        n = '0;
        if (rst_i) return n;
        hs = can_issue(m, n_max) && valid_i && rdy_i;
        after = m.inflight + (hs ? 1 : 0) - (done_i ? 1 : 0);
        uf = (after < 0);
        if (uf) after = 0;
        te = 1'b0;
        n = m;
        n.waited = 0;
        if (m.mode == M_ACT) begin
            if (dreq_i) n.mode = M_DRN;
        end else if (m.mode == M_DRN) begin
            if (!dreq_i) n.mode = M_ACT;
            else if (after == 0) n.mode = M_DEC;
            else if (t_max != 0 && m.waited == t_max - 1) begin
                n.mode = M_DEC;
                te = 1'b1;
            end else n.waited = m.waited + 1;
        end else begin
            if (!dreq_i) n.mode = M_ACT;
        end
        if (n.mode == M_DEC) begin
            after = 0;
            uf = 1'b0;
        end
        n.inflight = after;
        n.dcpl = (n.mode == M_DEC);
        n.to_flag = te ? 1'b1 : (clr_i ? 1'b0 : m.to_flag);
        n.uf_flag = uf ? 1'b1 : (clr_i ? 1'b0 : m.uf_flag);
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: check pass-through and gating mid-cycle, step models, check state.
    task automatic cycle();
        mdl_t na;
        mdl_t nb;
        logic [95:0] rnd;
        rnd = {$urandom(), $urandom(), $urandom()};
        req_i = rnd[$bits(dma_req_t)-1:0];
        #1;
        chk("a_ready", 32'(sa.ready), 32'(rdy_i && can_issue(ma_m, NA)));
        chk("a_valid", 32'(ma.valid), 32'(valid_i && can_issue(ma_m, NA)));
        chk("a_rsp", 32'(sa.rsp.done), 32'(done_i));
        chk("b_ready", 32'(sb.ready), 32'(rdy_i && can_issue(mb_m, NB)));
        chk("b_valid", 32'(mb.valid), 32'(valid_i && can_issue(mb_m, NB)));
        chk("b_rsp", 32'(sb.rsp.done), 32'(done_i));
        n_vec++;
        assert (ma.req === req_i && mb.req === req_i) else begin
            n_mis++;
            $error("FAIL req_pass observed=%0h expected=%0h", ma.req, req_i);
        end
        if (valid_i && sa.ready) hs_a++;
        na = step(ma_m, NA, TA);
        nb = step(mb_m, NB, TB);
        @(posedge clk);
        ma_m = na;
        mb_m = nb;
        @(negedge clk);
        chk("a_decouple", 32'(dcpl_a), 32'(ma_m.dcpl));
        chk("a_busy", 32'(busy_a), 32'(ma_m.mode == M_DRN));
        chk("a_outstanding", 32'(out_a), ma_m.inflight);
        chk("a_timeout_flag", 32'(to_a), 32'(ma_m.to_flag));
        chk("a_underflow_flag", 32'(uf_a), 32'(ma_m.uf_flag));
        chk("b_decouple", 32'(dcpl_b), 32'(mb_m.dcpl));
        chk("b_busy", 32'(busy_b), 32'(mb_m.mode == M_DRN));
        chk("b_outstanding", 32'(out_b), mb_m.inflight);
        chk("b_timeout_flag", 32'(to_b), 32'(mb_m.to_flag));
        chk("b_underflow_flag", 32'(uf_b), 32'(mb_m.uf_flag));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        cycle();
        chk("rst_out", 32'(out_a), 0);
        chk("rst_decouple", 32'(dcpl_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        rst_i = 1'b0;

        // Credit limit: exactly 4 handshakes, then one done frees one credit
        valid_i = 1'b1; rdy_i = 1'b1; hs_a = 0;
        run(6);
        chk("credit_hs", hs_a, 4);
        chk("credit_out", 32'(out_a), 4);
        chk("credit_ready", 32'(sa.ready), 0);
        done_i = 1'b1; cycle();
        chk("credit_done_out", 32'(out_a), 3);
        chk("credit_done_hs", hs_a, 4);
        done_i = 1'b0; cycle();
        chk("credit_fifth_hs", hs_a, 5);

        // Clean drain: 3 in flight, completions at +2, +5, +9
        valid_i = 1'b0; done_i = 1'b1; cycle();
        done_i = 1'b0; dreq_i = 1'b1; cycle();
        chk("drain_busy", 32'(busy_a), 1);
        valid_i = 1'b1; hs_base = hs_a;
        for (int k = 1; k <= 9; k++) begin
            done_i = (k == 2 || k == 5 || k == 9);
            cycle();
            chk("drain_out", 32'(out_a), (k < 2) ? 3 : (k < 5) ? 2 : (k < 9) ? 1 : 0);
            chk("drain_decouple", 32'(dcpl_a), (k == 9) ? 1 : 0);
        end
        done_i = 1'b0;
        chk("drain_no_hs", hs_a, hs_base);
        chk("drain_no_timeout", 32'(to_a), 0);
        dreq_i = 1'b0; valid_i = 1'b0; cycle();
        chk("release_decouple", 32'(dcpl_a), 0);

        // Timeout: 2 in flight, no completions, decouple 17 cycles after the request
        valid_i = 1'b1; run(2);
        valid_i = 1'b0; dreq_i = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            cycle();
            chk("to_decouple", 32'(dcpl_a), (k == 16) ? 1 : 0);
            chk("to_flag", 32'(to_a), (k == 16) ? 1 : 0);
        end
        chk("to_out", 32'(out_a), 0);
        chk("to_b_waits", 32'(busy_b), 1);
        chk("to_b_no_decouple", 32'(dcpl_b), 0);
        dreq_i = 1'b0; cycle();
        chk("to_flag_sticky", 32'(to_a), 1);
        clr_i = 1'b1; cycle();
        clr_i = 1'b0;
        chk("to_flag_clr", 32'(to_a), 0);

        // Simultaneous inc/dec, underflow, set-over-clear
        valid_i = 1'b1; run(2);
        done_i = 1'b1; cycle();
        chk("incdec_out", 32'(out_a), 2);
        valid_i = 1'b0; run(2);
        chk("dec_out", 32'(out_a), 0);
        cycle();
        chk("uf_flag", 32'(uf_a), 1);
        chk("uf_out", 32'(out_a), 0);
        clr_i = 1'b1; cycle();
        chk("uf_set_wins", 32'(uf_a), 1);
        done_i = 1'b0; cycle();
        chk("uf_clr", 32'(uf_a), 0);
        clr_i = 1'b0; valid_i = 1'b1; done_i = 1'b1; cycle();
        chk("incdec_zero_out", 32'(out_a), 0);
        chk("incdec_zero_flag", 32'(uf_a), 0);
        done_i = 1'b0;

        // Abort drain with 1 in flight
        cycle();
        valid_i = 1'b0; dreq_i = 1'b1; cycle();
        chk("abort_busy", 32'(busy_a), 1);
        cycle();
        chk("abort_no_decouple", 32'(dcpl_a), 0);
        dreq_i = 1'b0; cycle();
        chk("abort_busy_off", 32'(busy_a), 0);
        chk("abort_out", 32'(out_a), 1);
        chk("abort_decouple", 32'(dcpl_a), 0);
        valid_i = 1'b1; hs_base = hs_a; cycle();
        chk("abort_resume_hs", hs_a, hs_base + 1);

        // Reset mid-drain with 5 in flight on the wide instance
        rst_i = 1'b1; valid_i = 1'b0; cycle();
        rst_i = 1'b0; done_i = 1'b1; cycle();
        done_i = 1'b0; valid_i = 1'b1; run(5);
        valid_i = 1'b0; dreq_i = 1'b1; run(2);
        chk("rstd_b_out", 32'(out_b), 5);
        chk("rstd_b_busy", 32'(busy_b), 1);
        chk("rstd_b_uf", 32'(uf_b), 1);
        rst_i = 1'b1; dreq_i = 1'b0; cycle();
        rst_i = 1'b0;
        chk("rstd_b_out0", 32'(out_b), 0);
        chk("rstd_b_busy0", 32'(busy_b), 0);
        chk("rstd_b_uf0", 32'(uf_b), 0);
        chk("rstd_b_decouple0", 32'(dcpl_b), 0);
        rdy_i = 1'b1; #1;
        chk("rstd_ready_hi", 32'(sb.ready), 1);
        rdy_i = 1'b0; #1;
        chk("rstd_ready_lo", 32'(sb.ready), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_i   = ($urandom_range(0, 149) == 0);
            valid_i = ($urandom_range(0, 3) != 0);
            rdy_i   = ($urandom_range(0, 2) != 0);
            done_i  = ($urandom_range(0, 2) == 0);
            clr_i   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) dreq_i = ~dreq_i;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
